// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder: access sizes, ctrl bit
// positions, default array size and small lane helpers.
package data_mem_responder_pkg;

  localparam int XLEN              = 64;
  localparam int DEFAULT_MEM_BYTES = 4096;

  localparam int CTRL_WRITE    = 2;
  localparam int CTRL_READ     = 1;
  localparam int CTRL_REGWRITE = 0;

  typedef enum logic [2:0] {
    SZ_B   = 3'b000,
    SZ_H   = 3'b001,
    SZ_W   = 3'b010,
    SZ_D   = 3'b011,
    SZ_BU  = 3'b100,
    SZ_HU  = 3'b101,
    SZ_WU  = 3'b110,
    SZ_BAD = 3'b111
  } size_e;

  // sz is log2 of the access width in bytes (funct3[1:0])
  function automatic logic [7:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU-side data bus bundle: the CPU drives address/data/control, the
// responder returns load data and the fault flag.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [2:0]      ctrl;
  logic [2:0]      size;
  logic [XLEN-1:0] rdata;
  logic            fault;

  modport master (output addr, wdata, ctrl, size, input rdata, fault);
  modport slave  (input addr, wdata, ctrl, size, output rdata, fault);
endinterface

// File: rtl/data_mem_responder_store_buffer.sv
// Single-entry store buffer: holds one lane-aligned 8-byte word write and
// merges its masked bytes over array read data for forwarding.
module store_buffer #(
  parameter int WORD_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              valid,
  input  logic [WORD_W-1:0] cap_word,
  input  logic [7:0]        cap_mask,
  input  logic [63:0]       cap_data,
  input  logic [WORD_W-1:0] rd_word,
  input  logic [63:0]       arr_data,
  output logic [WORD_W-1:0] buf_word,
  output logic [7:0]        buf_mask,
  output logic [63:0]       buf_data,
  output logic [63:0]       merged
);

  logic hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_word <= '0;
      buf_mask <= '0;
      buf_data <= '0;
    end else if (capture) begin
      buf_word <= cap_word;
      buf_mask <= cap_mask;
      buf_data <= cap_data;
    end
  end

  assign hit = valid && (buf_word == rd_word);

  always_comb begin
    merged = arr_data;
    for (int i = 0; i < 8; i++) begin
      if (hit && buf_mask[i]) merged[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory with combinational loads and a one-deep store
// buffer. Optional access counters are enabled by defining MEM_STATS_EN.
//
// state   | meaning
// IDLE    | store buffer empty
// PENDING | store buffer holds a write, committed at the next edge
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic clk,
  input  logic rst_n,
  data_mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int IW = $clog2(MEM_BYTES);
  localparam int WW = IW - 3;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [7:0]    mem [MEM_BYTES];
  logic [0:0]    state, state_nxt;
  logic [IW-1:0] idx;
  logic [2:0]    off;
  logic [WW-1:0] word;
  logic [1:0]    sz;
  logic          access, illegal, fault_c, do_read, do_write, sext;
  logic [63:0]   arr_word, merged, shifted, ext;
  logic [WW-1:0] buf_word;
  logic [7:0]    buf_mask;
  logic [63:0]   buf_data;
  logic          buf_valid;
  logic          unused_bits;

  assign idx  = bus.addr[IW-1:0];
  assign off  = idx[2:0];
  assign word = idx[IW-1:3];
  assign sz   = bus.size[1:0];
  assign sext = ~bus.size[2];

  // upper address bits wrap silently; regwrite is the CPU's concern only
  assign unused_bits = ^{bus.addr[XLEN-1:IW], bus.ctrl[CTRL_REGWRITE]};

  assign access   = bus.ctrl[CTRL_WRITE] | bus.ctrl[CTRL_READ];
  assign illegal  = (bus.size == SZ_BAD) | misaligned(sz, off)
                  | (bus.ctrl[CTRL_WRITE] & bus.ctrl[CTRL_READ]);
  assign fault_c  = rst_n & access & illegal;
  assign do_read  = rst_n & bus.ctrl[CTRL_READ] & ~fault_c;
  assign do_write = rst_n & bus.ctrl[CTRL_WRITE] & ~fault_c;
  assign buf_valid = (state == PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_write) state_nxt = PENDING;
      PENDING: state_nxt = do_write ? PENDING : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // array is deliberately not reset; a cleared buffer simply stops commits
  always_ff @(posedge clk) begin
    if (buf_valid) begin
      for (int i = 0; i < 8; i++) begin
        if (buf_mask[i]) mem[{buf_word, 3'(i)}] <= buf_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    arr_word = '0;
    for (int i = 0; i < 8; i++) arr_word[8*i +: 8] = mem[{word, 3'(i)}];
  end

  store_buffer #(.WORD_W(WW)) u_store_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (do_write),
    .valid    (buf_valid),
    .cap_word (word),
    .cap_mask (lane_mask(sz) << off),
    .cap_data (bus.wdata << {off, 3'b000}),
    .rd_word  (word),
    .arr_data (arr_word),
    .buf_word (buf_word),
    .buf_mask (buf_mask),
    .buf_data (buf_data),
    .merged   (merged)
  );

  assign shifted = merged >> {off, 3'b000};

  always_comb begin
    case (sz)
      2'd0:    ext = {{56{shifted[7]  & sext}}, shifted[7:0]};
      2'd1:    ext = {{48{shifted[15] & sext}}, shifted[15:0]};
      2'd2:    ext = {{32{shifted[31] & sext}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  assign bus.rdata = do_read ? ext : '0;
  assign bus.fault = fault_c;

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (do_read && rd_count != '1)  rd_count <= rd_count + 32'd1;
      if (do_write && wr_count != '1) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: byte-level reference model,
// directed literal checks and randomized traffic (stats checked with MEM_STATS_EN).
module tb_data_mem_responder;

  localparam int MEM = 4096;
  localparam logic [2:0] WR = 3'b100;
  localparam logic [2:0] RD = 3'b010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  data_mem_responder_if bus_if ();
`ifdef MEM_STATS_EN
  logic [31:0] rd_count, wr_count;
`endif

  data_mem_responder #(.MEM_BYTES(MEM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
`ifdef MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  // reference: committed bytes plus the list of bytes still waiting to land
  logic [7:0] mm [MEM];
  int         pend_n = 0;
  int         pend_idx [8];
  logic [7:0] pend_val [8];

  function automatic int nbytes(input logic [2:0] s);
    return 1 << (s % 4);
  endfunction

  function automatic logic model_fault();
    if (!rst_n) return 1'b0;
    if (!(bus_if.ctrl[2] || bus_if.ctrl[1])) return 1'b0;
    if (bus_if.size == 3'd7) return 1'b1;
    if (bus_if.ctrl[2] && bus_if.ctrl[1]) return 1'b1;
    return (bus_if.addr % 64'(nbytes(bus_if.size))) != 0;
  endfunction

  function automatic logic [7:0] view(input int i);
    for (int k = 0; k < pend_n; k++) if (pend_idx[k] == i) return pend_val[k];
    return mm[i];
  endfunction

  function automatic logic [63:0] model_rdata(input logic f);
    logic [63:0] v;
    int n, base;
    if (!rst_n || !bus_if.ctrl[1] || f) return 64'd0;
    n = nbytes(bus_if.size);
    base = int'(bus_if.addr % 64'(MEM));
    v = 64'd0;
    for (int k = 0; k < n; k++) v |= 64'(view(base + k)) << (8 * k);
    if (bus_if.size < 3'd3 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  always @(posedge clk) begin
    logic wr_ok;
    int base;
    wr_ok = bus_if.ctrl[2] && !model_fault();
    if (!rst_n) pend_n = 0;
    else begin
      for (int k = 0; k < pend_n; k++) mm[pend_idx[k]] = pend_val[k];
      pend_n = 0;
      if (wr_ok) begin
        base = int'(bus_if.addr % 64'(MEM));
        pend_n = nbytes(bus_if.size);
        for (int k = 0; k < pend_n; k++) begin
          pend_idx[k] = base + k;
          pend_val[k] = 8'(bus_if.wdata >> (8 * k));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic ef;
    logic [63:0] er;
    if (chk_en) begin
      ef = model_fault();
      er = model_rdata(ef);
      total++;
      if (bus_if.fault !== ef) begin
        bad++;
        $display("FAIL model_fault t=%0t addr=%h ctrl=%b size=%b got=%b exp=%b",
                 $time, bus_if.addr, bus_if.ctrl, bus_if.size, bus_if.fault, ef);
      end
      total++;
      if (bus_if.rdata !== er) begin
        bad++;
        $display("FAIL model_rdata t=%0t addr=%h ctrl=%b size=%b got=%h exp=%h",
                 $time, bus_if.addr, bus_if.ctrl, bus_if.size, bus_if.rdata, er);
      end
    end
  end

  task automatic drive(input logic [2:0] c, input logic [2:0] s,
                       input logic [63:0] a, input logic [63:0] d);
    bus_if.ctrl = c;
    bus_if.size = s;
    bus_if.addr = a;
    bus_if.wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic op_chk(input logic [2:0] c, input logic [2:0] s, input logic [63:0] a,
                        input logic [63:0] d, input string name,
                        input logic [63:0] exp_r, input logic exp_f);
    drive(c, s, a, d);
    @(negedge clk);
    lit({name, "_rdata"}, bus_if.rdata, exp_r);
    lit({name, "_fault"}, 64'(bus_if.fault), 64'(exp_f));
    step();
  endtask

  task automatic op(input logic [2:0] c, input logic [2:0] s,
                    input logic [63:0] a, input logic [63:0] d);
    drive(c, s, a, d);
    step();
  endtask

  initial begin
    logic [63:0] a, d, hi;
    logic [2:0] c, s;
    int idx, r;

    drive(RD, 3'b011, 64'h10, 64'd0);
    chk_en = 1'b1;
    step();
    op_chk(RD, 3'b011, 64'h10, 64'd0, "reset_read", 64'd0, 1'b0);
    op_chk(WR, 3'b010, 64'h102, 64'd0, "reset_nofault", 64'd0, 1'b0);
    rst_n = 1'b1;

    for (int k = 0; k < 64; k++) op(WR, 3'b011, 64'(8 * k), {$urandom, $urandom});
    op(WR, 3'b011, 64'h100, 64'h0123456789ABCDEF);
    op(WR, 3'b011, 64'h40, 64'hCAFEF00D12345678);
    op(3'b000, 3'b000, 64'd0, 64'd0);

    // store forwarded, then resident
    op(WR, 3'b011, 64'h10, 64'h1122334455667788);
    op_chk(RD, 3'b011, 64'h10, 64'd0, "ld_fwd", 64'h1122334455667788, 1'b0);
    op(3'b000, 3'b000, 64'd0, 64'd0);
    op_chk(RD, 3'b011, 64'h10, 64'd0, "ld_array", 64'h1122334455667788, 1'b0);

    op(WR, 3'b000, 64'h21, 64'hFF);
    op_chk(RD, 3'b000, 64'h21, 64'd0, "lb_sext", 64'hFFFFFFFFFFFFFFFF, 1'b0);
    op_chk(RD, 3'b100, 64'h21, 64'd0, "lbu_zext", 64'h00000000000000FF, 1'b0);

    op(WR, 3'b010, 64'h0, 64'hAAAAAAAA);
    op(WR, 3'b010, 64'h4, 64'h55555555);
    op_chk(RD, 3'b011, 64'h0, 64'd0, "ld_merge", 64'h55555555AAAAAAAA, 1'b0);

    op_chk(WR, 3'b010, 64'h102, 64'h0BADF00D, "sw_misalign", 64'd0, 1'b1);
    op_chk(RD, 3'b010, 64'h100, 64'd0, "lw_prior", 64'hFFFFFFFF89ABCDEF, 1'b0);
    op_chk(3'b110, 3'b000, 64'h100, 64'd0, "ctrl_110", 64'd0, 1'b1);
    op_chk(RD, 3'b111, 64'h100, 64'd0, "size_111", 64'd0, 1'b1);
    op_chk(RD, 3'b011, 64'hABCD_0000_0000_1100, 64'd0, "wrap_hi", 64'h0123456789ABCDEF, 1'b0);

    // reset while a store sits in the buffer
    op(WR, 3'b011, 64'h40, 64'hDEAD);
    rst_n = 1'b0;
    op_chk(RD, 3'b011, 64'h40, 64'd0, "rst_hold", 64'd0, 1'b0);
    rst_n = 1'b1;
    op_chk(RD, 3'b011, 64'h40, 64'd0, "rst_lost", 64'hCAFEF00D12345678, 1'b0);

    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      c = (r < 40) ? RD : (r < 80) ? WR : 3'($urandom_range(0, 7));
      c[0] = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 19) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      idx = int'($urandom_range(0, 511));
      if ($urandom_range(0, 4) != 0) idx = idx & ~(nbytes(s) - 1);
      hi = {$urandom, $urandom};
      a = {hi[63:12], 12'(idx)};
      d = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 99) != 0);
      op(c, s, a, d);
    end
    rst_n = 1'b1;

`ifdef MEM_STATS_EN
    rst_n = 1'b0;
    op(3'b000, 3'b000, 64'd0, 64'd0);
    rst_n = 1'b1;
    lit("stats_reset_rd", 64'(rd_count), 64'd0);
    lit("stats_reset_wr", 64'(wr_count), 64'd0);
    op(RD, 3'b011, 64'h10, 64'd0);
    op(WR, 3'b011, 64'h18, 64'h77);
    op(RD, 3'b000, 64'h21, 64'd0);
    op(WR, 3'b010, 64'h102, 64'h1);
    op(WR, 3'b001, 64'h20, 64'h1234);
    op(RD, 3'b010, 64'h100, 64'd0);
    op(3'b000, 3'b000, 64'd0, 64'd0);
    lit("stats_rd", 64'(rd_count), 64'd3);
    lit("stats_wr", 64'(wr_count), 64'd2);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 4096; it is the byte-array size and SHALL be a power of two.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 addr  input  64  byte address, driven from the CPU AddressBus.
REQ-005 wdata  input  64  store data, driven from the CPU DataBusOut.
REQ-006 ctrl  input  3  control bus {write, read, regwrite}; bit0 is ignored.
REQ-007 size  input  3  access size, funct3 encoding: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu; 111 is illegal.
REQ-008 rdata  output  64  load data, returned to the CPU DataBusIn.
REQ-009 fault  output  1  illegal access in the current cycle.

Function
REQ-010 Byte index SHALL be addr mod MEM_BYTES; higher address bits wrap silently, and storage SHALL be little-endian.
REQ-011 Reads SHALL be combinational: ctrl[1]=1 with no fault gives rdata the access-sized value at addr, sign-extended for b/h/w and zero-extended for bu/hu/wu/d.
REQ-012 rdata SHALL be 0 when ctrl[1]=0, when fault=1, and while rst_n=0.
REQ-013 A fault SHALL be raised combinationally when ctrl[2] or ctrl[1] is set and any of these holds: addr is not aligned to the access size; size=111; or ctrl[2] and ctrl[1] are both set.
REQ-014 A faulting write SHALL be dropped, and the memory and buffer state SHALL be unchanged.
REQ-015 A non-faulting write (ctrl[2]=1) SHALL NOT update the array at that edge; at posedge it SHALL be captured into a single-entry store buffer holding address, data and byte mask.
REQ-016 The block SHALL have a two-state FSM: IDLE = buffer empty; PENDING = buffer valid.
REQ-017 IDLE SHALL move to PENDING on a captured write; with no write it SHALL stay IDLE.
REQ-018 In PENDING, each posedge SHALL commit the buffered bytes to the array.
REQ-019 In PENDING with a new write at the same edge, the block SHALL commit the old entry and capture the new one, staying PENDING; this sustains one write per cycle with no stall.
REQ-020 In PENDING with no new write, the FSM SHALL return to IDLE after the commit.
REQ-021 Reads SHALL forward per byte: a byte covered by a valid buffer mask SHALL return buffered data, and other bytes SHALL come from the array.
REQ-022 When a commit and a capture hit the same bytes at one edge, the new capture SHALL win for forwarding.
REQ-023 Store latency SHALL be: visible through forwarding in the cycle after the capture edge; resident in the array one edge later.

Reset
REQ-024 While rst_n=0 the FSM SHALL go to IDLE, the buffer SHALL be invalidated, fault SHALL be 0 and rdata SHALL be 0.
REQ-025 A pending write SHALL be lost when reset asserts mid-operation.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 Release of rst_n SHALL need no synchronizing cycle before the first access.

Configuration
REQ-028 With macro MEM_STATS_EN defined, the block SHALL add outputs rd_count and wr_count, each 32 bits; they reset to 0.
REQ-029 rd_count SHALL increment on each cycle with a non-faulting read, and wr_count on each captured write; both SHALL saturate at all-ones.
REQ-030 Without MEM_STATS_EN, neither the ports nor the counters SHALL exist.

Structure
REQ-031 A shared package SHALL hold the size encodings, the ctrl bit positions (WRITE=2, READ=1, REGWRITE=0) and the default MEM_BYTES.
REQ-032 The single-entry buffer and forwarding merge SHALL be sub-module store_buffer; the FSM, alignment checks and array SHALL remain in data_mem_responder.

Verification
REQ-033 sd 0x1122334455667788 @0x10, ld @0x10 the next cycle -> rdata 0x1122334455667788 (forwarded); ld again two cycles later -> the same value (from the array).
REQ-034 sb 0xFF @0x21, then lb @0x21 -> 0xFFFFFFFFFFFFFFFF; lbu @0x21 -> 0x00000000000000FF.
REQ-035 Back-to-back sw 0xAAAAAAAA @0x0 then sw 0x55555555 @0x4, then ld @0x0 -> 0x55555555AAAAAAAA (one half from the array, one forwarded).
REQ-036 sw @0x102 -> fault=1, rdata=0; a following lw @0x100 returns its prior contents; ctrl=110 -> fault=1.
REQ-037 Assert rst_n low in PENDING holding sd 0xDEAD @0x40 -> after release, ld @0x40 returns the old contents.
REQ-038 With MEM_STATS_EN: 3 good reads, 2 good writes, 1 faulting write -> rd_count=3, wr_count=2.
